// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard entry type and operand-select constants
package hazard_pkg;
  localparam int MAX_AW = 16;
  localparam int FWD_RF = 0;
  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_read;
    logic [MAX_AW-1:0] dest;
  } entry_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage request and hazard-unit response bundle
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
);
  localparam int SEL_W = $clog2(DEPTH + 1);
  logic              id_valid;
  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;
  logic              isSrc2;
  logic [REG_AW-1:0] id_dest;
  logic              id_wb_en;
  logic              id_mem_read;
  logic              flush;
  logic              cnt_clr;
  logic              freez;
  logic [SEL_W-1:0]  fwd_sel1;
  logic [SEL_W-1:0]  fwd_sel2;
  logic [CNT_W-1:0]  stall_cnt;
  modport master (
    output id_valid, src1, src2, isSrc2, id_dest, id_wb_en, id_mem_read, flush, cnt_clr,
    input  freez, fwd_sel1, fwd_sel2, stall_cnt
  );
  modport slave (
    input  id_valid, src1, src2, isSrc2, id_dest, id_wb_en, id_mem_read, flush, cnt_clr,
    output freez, fwd_sel1, fwd_sel2, stall_cnt
  );
endinterface

// File: rtl/hazard_match.sv
// hazard_match: youngest in-flight producer of one source operand
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 1,
  parameter int ZERO_REG   = 0,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  entry_t [DEPTH-1:0] ent,
  input  logic [REG_AW-1:0]  src,
  input  logic               en,
  output logic               found,
  output logic [SEL_W-1:0]   idx,
  output logic               load_stall
);
  logic live;
  assign live = en && !(ZERO_REG != 0 && src == '0);
  // scan oldest to youngest so the youngest hit overwrites older ones
  always_comb begin
    found      = 1'b0;
    idx        = '0;
    load_stall = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--)
      if (live && ent[k].valid && ent[k].wb_en && ent[k].dest == MAX_AW'(src)) begin
        found      = 1'b1;
        idx        = SEL_W'(k);
        load_stall = ent[k].mem_read && k < LOAD_STAGE;
      end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: post-ID destination scoreboard driving freeze and forwarding
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 2,
  parameter int FWD_EN     = 1,
  parameter int LOAD_STAGE = 1,
  parameter int ZERO_REG   = 0,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave bus
);
  localparam int SEL_W = $clog2(DEPTH + 1);
  entry_t [DEPTH-1:0] ent;
  entry_t             fill;
  logic               f1, f2, l1, l2, freez;
  logic [SEL_W-1:0]   i1, i2;
  logic [CNT_W-1:0]   cnt;
  hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)) u_m1 (
    .ent(ent), .src(bus.src1), .en(bus.id_valid), .found(f1), .idx(i1), .load_stall(l1)
  );
  hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)) u_m2 (
    .ent(ent), .src(bus.src2), .en(bus.id_valid && bus.isSrc2), .found(f2), .idx(i2), .load_stall(l2)
  );
  assign freez         = FWD_EN != 0 ? l1 || l2 : f1 || f2;
  assign bus.freez     = freez;
  assign bus.fwd_sel1  = FWD_EN != 0 && f1 && !l1 ? i1 + SEL_W'(1) : SEL_W'(FWD_RF);
  assign bus.fwd_sel2  = FWD_EN != 0 && f2 && !l2 ? i2 + SEL_W'(1) : SEL_W'(FWD_RF);
  assign bus.stall_cnt = cnt;
  assign fill = bus.id_valid && !freez && !bus.flush
              ? entry_t'{valid: 1'b1, wb_en: bus.id_wb_en, mem_read: bus.id_mem_read, dest: MAX_AW'(bus.id_dest)}
              : '0;
  // advance every tracked stage; ID issues into EXE or a bubble takes its place
  always_ff @(posedge clk or negedge rst)
    if (!rst) ent <= '0;
    else      ent <= {ent[DEPTH-2:0], fill};
  // saturating freeze-cycle counter, clear wins
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else      cnt <= bus.cnt_clr ? '0 : freez && !(&cnt) ? cnt + CNT_W'(1) : cnt;
endmodule
